systolic_sequencer: RTL and testbench
=====================================

Name: systolic_sequencer

Overview:
Job controller that sits between the operand/result buffers and a systolic MAC array of array_height_p x array_width_p cells.
- Accepts one matrix-multiply job: an H×K operand A and a K×W operand B, streamed one k-beat at a time.
- Applies the diagonal skew the array needs and issues per-row flush tagged to the last beat of each lane.
- Drains the H*W accumulators as a single serial result stream in row-major order.

Parameters:
width_p, 32, operand/accumulator width
array_width_p, 2, array columns (W)
array_height_p, 2, array rows (H)
k_width_p, 16, width of the inner-dimension count k_i

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
start_i  in  1  start job, sampled in IDLE only
k_i  in  k_width_p  inner dimension K, latched on start
busy_o  out  1  high from accepted start until done_o
done_o  out  1  one-cycle pulse at job end
a_i  in  width_p*H  beat k: lane i = A[i][k]
a_valid_i  in  1  A beat valid
a_ready_o  out  1  A beat accepted when valid&ready
b_i  in  width_p*W  beat k: lane j = B[k][j]
b_valid_i  in  1  B beat valid
b_ready_o  out  1  B beat accepted when valid&ready
row_o  out  width_p*H  skewed row data to array
row_valid_o  out  H  per-row valid
row_ready_i  in  H  per-row ready from array
col_o  out  width_p*W  skewed column data to array
col_valid_o  out  W  per-column valid
col_ready_i  in  W  per-column ready from array
flush_o  out  H  per-row flush to array
en_o  out  1  array enable
z_i  in  width_p*W*H  accumulator bus from array
z_valid_i  in  W*H  accumulator valids
z_yumi_o  out  W*H  accumulator consume
res_o  out  width_p  result data
res_idx_o  out  $clog2(W*H)  result index, i*W+j
res_valid_o  out  1  result valid
res_ready_i  in  1  result ready

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE. Skew pipes and counters are cleared. A reset mid-job discards all in-flight data; no done_o is issued.

States and transitions:
- IDLE → FEED on start_i with k_i>0. K is latched and the beat counter is cleared.
- IDLE → DONE on start_i with k_i==0.
- FEED → SKEW after K beats are accepted.
- SKEW → DRAIN once every skew pipe is empty.
- DRAIN → DONE after H*W results have been transferred.
- DONE → IDLE after one cycle; done_o=1 in DONE.
- start_i is ignored outside IDLE.

Beat acceptance:
- A beat is accepted only in FEED, when a_valid_i & b_valid_i & adv.
- adv = &row_ready_i & &col_ready_i.
- a_ready_o = b_ready_o = FEED & a_valid_i & b_valid_i & adv. A and B are always consumed together.

Skew pipes:
- Row lane i has a pipe of depth i+1; column lane j has a pipe of depth j+1.
- Each stage holds {data, valid, last}, where last marks beat K-1.
- All pipes shift only when adv=1; on adv=0 every pipe holds.
- Latency: lane i output is valid i+1 adv-cycles after acceptance.
- Bubbles (no accepted beat) insert valid=0.
- en_o = busy_o & adv.

Output mapping:
- row_valid_o[i] and row_o lane i come from the output stage of pipe i; column lanes likewise.
- flush_o[i] = output-stage valid & last of row pipe i. It is a single cycle, coincident with the final element of lane i.

Drain:
- The scan pointer p runs 0..H*W-1, with row i=p/W and column j=p%W.
- The array slot for (i,j) is s = i + j*array_width_p.
- res_valid_o = DRAIN & z_valid_i[s], with res_o = z_i slot s and res_idx_o = p.
- z_yumi_o[s] = res_valid_o & res_ready_i, combinational; all other yumi bits are 0.
- p increments on transfer.

Arithmetic and edge cases:
- The beat counter is k_width_p bits and compares against K-1, with no wrap.
- res_ready_i low holds res_o/res_idx_o stable.

Optional Feature:
SYSTOLIC_SEQ_PERF_EN
- Defined: adds outputs cycles_o[31:0], the count of busy_o cycles, and stall_o[31:0], the count of FEED/SKEW cycles with adv=0.
- Both counters clear on start acceptance and on reset, saturate at all-ones, and hold after done.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Basic 2x2, K=2, width 32: A beats (1,3),(2,4) and B beats (5,6),(7,8) with ready/valid always high → results idx0..3 = 19,22,43,50, done_o one pulse, busy_o low after.
- Skew check, same job → row_valid_o[1] rises exactly one cycle after row_valid_o[0]; flush_o[0] coincides with lane-0 value 2 and flush_o[1] with lane-1 value 4.
- Backpressure: drop row_ready_i[1] for 3 cycles mid-FEED → a_ready_o=0 and en_o=0 for those cycles, pipes hold, final results still 19,22,43,50.
- Result stall: res_ready_i low for 5 cycles in DRAIN → res_o/res_idx_o stable and z_yumi_o=0 while stalled, then order 0,1,2,3.
- k_i=0 start → done_o one cycle after start, no res_valid_o, no a_ready_o.
- Reset asserted mid-FEED after 1 beat → all outputs 0 next cycle; a fresh K=2 job then completes correctly.

Source files
------------

// File: rtl/systolic_sequencer.sv
// Job controller for an H x W systolic MAC array: feeds skewed A/B beats, then drains results row-major.
// Optional cycle/stall counters are built when SYSTOLIC_SEQ_PERF_EN is defined.
module systolic_sequencer #(
   parameter int width_p        = 32,
   parameter int array_width_p  = 2,
   parameter int array_height_p = 2,
   parameter int k_width_p      = 16,
   localparam int cells_lp      = array_width_p * array_height_p,
   localparam int idx_w_lp      = (cells_lp > 1) ? $clog2(cells_lp) : 1
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic                                 start_i,
   input  logic [k_width_p-1:0]                 k_i,
   output logic                                 busy_o,
   output logic                                 done_o,
`ifdef SYSTOLIC_SEQ_PERF_EN
   output logic [31:0]                          cycles_o,
   output logic [31:0]                          stall_o,
`endif
   input  logic [width_p*array_height_p-1:0]    a_i,
   input  logic                                 a_valid_i,
   output logic                                 a_ready_o,
   input  logic [width_p*array_width_p-1:0]     b_i,
   input  logic                                 b_valid_i,
   output logic                                 b_ready_o,
   output logic [width_p*array_height_p-1:0]    row_o,
   output logic [array_height_p-1:0]            row_valid_o,
   input  logic [array_height_p-1:0]            row_ready_i,
   output logic [width_p*array_width_p-1:0]     col_o,
   output logic [array_width_p-1:0]             col_valid_o,
   input  logic [array_width_p-1:0]             col_ready_i,
   output logic [array_height_p-1:0]            flush_o,
   output logic                                 en_o,
   input  logic [width_p*cells_lp-1:0]          z_i,
   input  logic [cells_lp-1:0]                  z_valid_i,
   output logic [cells_lp-1:0]                  z_yumi_o,
   output logic [width_p-1:0]                   res_o,
   output logic [idx_w_lp-1:0]                  res_idx_o,
   output logic                                 res_valid_o,
   input  logic                                 res_ready_i
);

   typedef enum logic [2:0] {IDLE, FEED, SKEW, DRAIN, DONE} state_e;

   state_e                    state;
   logic [k_width_p-1:0]      k_len;
   logic [k_width_p-1:0]      beat;
   logic [idx_w_lp-1:0]       p;
   logic [idx_w_lp-1:0]       slot;
   logic                      adv;
   logic                      accept;
   logic                      last_beat;
   logic                      drain;
   logic                      xfer;
   logic                      pipe_busy;
   logic [array_height_p-1:0] row_busy;
   logic [array_width_p-1:0]  col_busy;
   logic [width_p-1:0]        z_lane [cells_lp];

   assign adv       = &row_ready_i & &col_ready_i;
   assign last_beat = (beat == k_len - k_width_p'(1));
   assign accept    = (state == FEED) & a_valid_i & b_valid_i & adv;
   assign a_ready_o = accept;
   assign b_ready_o = accept;
   assign en_o      = busy_o & adv;
   assign pipe_busy = (|row_busy) | (|col_busy);

   // Row skew pipes: lane i is i+1 stages deep and carries the last-beat tag for flush.
   for (genvar gi = 0; gi < array_height_p; gi++) begin : g_row
      logic [width_p-1:0] d [gi+1];
      logic               v [gi+1];
      logic               l [gi+1];
      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            for (int s = 0; s <= gi; s++) begin
               d[s] <= '0;
               v[s] <= 1'b0;
               l[s] <= 1'b0;
            end
         end else if (adv) begin
            d[0] <= accept ? a_i[gi*width_p +: width_p] : '0;
            v[0] <= accept;
            l[0] <= accept & last_beat;
            for (int s = 1; s <= gi; s++) begin
               d[s] <= d[s-1];
               v[s] <= v[s-1];
               l[s] <= l[s-1];
            end
         end
      end
      always_comb begin
         row_busy[gi] = 1'b0;
         for (int s = 0; s <= gi; s++) row_busy[gi] = row_busy[gi] | v[s];
      end
      assign row_o[gi*width_p +: width_p] = d[gi];
      assign row_valid_o[gi]              = v[gi];
      assign flush_o[gi]                  = v[gi] & l[gi];
   end

   // Column skew pipes: lane j is j+1 stages deep.
   for (genvar gj = 0; gj < array_width_p; gj++) begin : g_col
      logic [width_p-1:0] d [gj+1];
      logic               v [gj+1];
      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            for (int s = 0; s <= gj; s++) begin
               d[s] <= '0;
               v[s] <= 1'b0;
            end
         end else if (adv) begin
            d[0] <= accept ? b_i[gj*width_p +: width_p] : '0;
            v[0] <= accept;
            for (int s = 1; s <= gj; s++) begin
               d[s] <= d[s-1];
               v[s] <= v[s-1];
            end
         end
      end
      always_comb begin
         col_busy[gj] = 1'b0;
         for (int s = 0; s <= gj; s++) col_busy[gj] = col_busy[gj] | v[s];
      end
      assign col_o[gj*width_p +: width_p] = d[gj];
      assign col_valid_o[gj]              = v[gj];
   end

   // Drain: scan pointer p is row-major, the array stores cell (i,j) at slot i + j*W.
   for (genvar gz = 0; gz < cells_lp; gz++) begin : g_z
      assign z_lane[gz] = z_i[gz*width_p +: width_p];
   end

   assign drain       = (state == DRAIN);
   assign slot        = idx_w_lp'((int'(p) / array_width_p) + (int'(p) % array_width_p) * array_width_p);
   assign res_valid_o = drain & z_valid_i[slot];
   assign res_o       = drain ? z_lane[slot] : '0;
   assign res_idx_o   = drain ? p : '0;
   assign xfer        = res_valid_o & res_ready_i;

   always_comb begin
      z_yumi_o = '0;
      if (xfer) z_yumi_o[slot] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state  <= IDLE;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         k_len  <= '0;
         beat   <= '0;
         p      <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: if (start_i) begin
               k_len <= k_i;
               beat  <= '0;
               p     <= '0;
               if (k_i != '0) begin
                  state  <= FEED;
                  busy_o <= 1'b1;
               end else begin
                  state  <= DONE;
                  done_o <= 1'b1;
               end
            end
            FEED: if (accept) begin
               if (last_beat) state <= SKEW;
               else           beat  <= beat + k_width_p'(1);
            end
            SKEW: if (!pipe_busy) state <= DRAIN;
            DRAIN: if (xfer) begin
               p <= p + idx_w_lp'(1);
               if (p == idx_w_lp'(cells_lp - 1)) begin
                  state  <= DONE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SYSTOLIC_SEQ_PERF_EN
   always_ff @(posedge clk_i) begin
      if (reset_i || (state == IDLE && start_i)) begin
         cycles_o <= '0;
         stall_o  <= '0;
      end else begin
         if (busy_o && cycles_o != '1) cycles_o <= cycles_o + 32'd1;
         if ((state == FEED || state == SKEW) && !adv && stall_o != '1) stall_o <= stall_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: table of fixed jobs, hand-written reset sequence, and random jobs
// checked against a matrix-product reference model and per-lane stream expectations.
module tb_systolic_sequencer;
   localparam int WD = 32, AW = 2, AH = 2, KW = 16, N = AW * AH, IDX_W = 2, KMAX = 8;
   localparam int BUDGET = 2000, NV = 6;

   logic                clk, reset_i, start_i, busy_o, done_o;
   logic [KW-1:0]       k_i;
   logic [WD*AH-1:0]    a_i, row_o;
   logic [WD*AW-1:0]    b_i, col_o;
   logic                a_valid_i, a_ready_o, b_valid_i, b_ready_o, en_o;
   logic [AH-1:0]       row_valid_o, row_ready_i, flush_o;
   logic [AW-1:0]       col_valid_o, col_ready_i;
   logic [WD*N-1:0]     z_i;
   logic [N-1:0]        z_valid_i, z_yumi_o;
   logic [WD-1:0]       res_o;
   logic [IDX_W-1:0]    res_idx_o;
   logic                res_valid_o, res_ready_i;
`ifdef SYSTOLIC_SEQ_PERF_EN
   logic [31:0]         cycles_o, stall_o;
`endif

   systolic_sequencer #(.width_p(WD), .array_width_p(AW), .array_height_p(AH), .k_width_p(KW)) dut (
      .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .k_i(k_i), .busy_o(busy_o), .done_o(done_o),
`ifdef SYSTOLIC_SEQ_PERF_EN
      .cycles_o(cycles_o), .stall_o(stall_o),
`endif
      .a_i(a_i), .a_valid_i(a_valid_i), .a_ready_o(a_ready_o),
      .b_i(b_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
      .row_o(row_o), .row_valid_o(row_valid_o), .row_ready_i(row_ready_i),
      .col_o(col_o), .col_valid_o(col_valid_o), .col_ready_i(col_ready_i),
      .flush_o(flush_o), .en_o(en_o), .z_i(z_i), .z_valid_i(z_valid_i), .z_yumi_o(z_yumi_o),
      .res_o(res_o), .res_idx_o(res_idx_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]                 k;
      logic [AH-1:0][3:0][15:0]   a;
      logic [3:0][AW-1:0][15:0]   b;
      logic [7:0]                 rs_at;
      logic [7:0]                 rs_len;
      logic [7:0]                 q_len;
      logic                       skew;
      logic [N-1:0][31:0]         ex;
   } vec_t;

   vec_t              vecs [NV];
   logic [31:0]       amat [AH][KMAX];
   logic [31:0]       bmat [KMAX][AW];
   logic [31:0]       exp_res [N];
   int                tests = 0, fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   function automatic logic [AH-1:0][3:0][15:0] mk_a(input int a00, a01, a02, a10, a11, a12);
      mk_a = '0;
      mk_a[0][0] = 16'(a00); mk_a[0][1] = 16'(a01); mk_a[0][2] = 16'(a02);
      mk_a[1][0] = 16'(a10); mk_a[1][1] = 16'(a11); mk_a[1][2] = 16'(a12);
   endfunction

   function automatic logic [3:0][AW-1:0][15:0] mk_b(input int b00, b01, b10, b11, b20, b21);
      mk_b = '0;
      mk_b[0][0] = 16'(b00); mk_b[0][1] = 16'(b01); mk_b[1][0] = 16'(b10);
      mk_b[1][1] = 16'(b11); mk_b[2][0] = 16'(b20); mk_b[2][1] = 16'(b21);
   endfunction

   function automatic logic [N-1:0][31:0] mk_e(input int e0, e1, e2, e3);
      mk_e[0] = 32'(e0); mk_e[1] = 32'(e1); mk_e[2] = 32'(e2); mk_e[3] = 32'(e3);
   endfunction

   // Reference model: C = A x B with 32-bit wrap, placed into the array's accumulator slots.
   task automatic load_job(input int k);
      logic [31:0] c;
      z_i = '0;
      for (int i = 0; i < AH; i++)
         for (int j = 0; j < AW; j++) begin
            c = 32'd0;
            for (int kk = 0; kk < k; kk++) c = c + amat[i][kk] * bmat[kk][j];
            z_i[(i + j*AW)*WD +: WD] = c;
         end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"}, busy_o, 0);       check({tag, "_done"}, done_o, 0);
      check({tag, "_a_ready"}, a_ready_o, 0); check({tag, "_b_ready"}, b_ready_o, 0);
      check({tag, "_row_valid"}, row_valid_o, 0); check({tag, "_row"}, row_o, 0);
      check({tag, "_col_valid"}, col_valid_o, 0); check({tag, "_col"}, col_o, 0);
      check({tag, "_flush"}, flush_o, 0);     check({tag, "_en"}, en_o, 0);
      check({tag, "_res_valid"}, res_valid_o, 0); check({tag, "_res"}, res_o, 0);
      check({tag, "_res_idx"}, res_idx_o, 0); check({tag, "_yumi"}, z_yumi_o, 0);
   endtask

   task automatic run_job(input int k, input int rs_at, input int rs_len, input int q_len,
                          input bit rnd, input bit chk_skew);
      int kb, nres, cnt_stall, done_cyc, slot;
      int lane_n [AH];
      int col_n [AW];
      int first_v [AH];
      bit done_seen, stream_ok, hs_ok, rs_ok, q_ok, q_done, q_snapped, adv;
      logic [WD-1:0] snap_val;
      logic [IDX_W-1:0] snap_idx;
      kb = 0; nres = 0; cnt_stall = 0; done_cyc = -1; done_seen = 0;
      stream_ok = 1; hs_ok = 1; rs_ok = 1; q_ok = 1; q_done = (q_len == 0); q_snapped = 0;
      snap_val = '0; snap_idx = '0;
      for (int i = 0; i < AH; i++) begin lane_n[i] = 0; first_v[i] = -1; end
      for (int j = 0; j < AW; j++) col_n[j] = 0;
      for (int c = 0; c < BUDGET; c++) begin
         @(negedge clk);
         start_i   = (c == 0) || (rnd && $urandom_range(0, 7) == 0);
         k_i       = (c == 0) ? KW'(k) : KW'($urandom_range(0, 9));
         a_valid_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         b_valid_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         a_i = '0; b_i = '0;
         if (kb < k) begin
            for (int i = 0; i < AH; i++) a_i[i*WD +: WD] = amat[i][kb];
            for (int j = 0; j < AW; j++) b_i[j*WD +: WD] = bmat[kb][j];
         end
         row_ready_i = '1; col_ready_i = '1;
         if (rnd) begin
            for (int i = 0; i < AH; i++) row_ready_i[i] = ($urandom_range(0, 4) != 0);
            for (int j = 0; j < AW; j++) col_ready_i[j] = ($urandom_range(0, 4) != 0);
         end
         if (c >= rs_at && c < rs_at + rs_len) row_ready_i[1] = 1'b0;
         res_ready_i = rnd ? ($urandom_range(0, 2) != 0) : q_done;
         #1;
         adv = &row_ready_i & &col_ready_i;
         if (c == 1) check("busy_mid", busy_o, (k > 0));
         if (rs_len > 0 && c >= rs_at && c < rs_at + rs_len && (a_ready_o || en_o)) rs_ok = 0;
         if (a_ready_o !== b_ready_o || (a_ready_o && !(a_valid_i && b_valid_i && adv))) hs_ok = 0;
         if (a_ready_o) kb++;
         for (int i = 0; i < AH; i++) begin
            if (flush_o[i] && !row_valid_o[i]) stream_ok = 0;
            if (row_valid_o[i] && adv) begin
               if (first_v[i] < 0) first_v[i] = c;
               if (lane_n[i] >= k || row_o[i*WD +: WD] !== amat[i][lane_n[i]] ||
                   flush_o[i] !== (lane_n[i] == k - 1)) stream_ok = 0;
               lane_n[i]++;
            end
         end
         for (int j = 0; j < AW; j++)
            if (col_valid_o[j] && adv) begin
               if (col_n[j] >= k || col_o[j*WD +: WD] !== bmat[col_n[j]][j]) stream_ok = 0;
               col_n[j]++;
            end
         if (res_valid_o && !res_ready_i && !rnd && !q_done) begin
            if (!q_snapped) begin
               snap_val = res_o; snap_idx = res_idx_o; q_snapped = 1;
            end else if (res_o !== snap_val || res_idx_o !== snap_idx) q_ok = 0;
            if (z_yumi_o != '0) q_ok = 0;
            cnt_stall++;
            if (cnt_stall == q_len) q_done = 1;
         end
         if (res_valid_o && res_ready_i) begin
            if (nres < N) begin
               slot = (nres / AW) + (nres % AW) * AW;
               check("res_idx", res_idx_o, nres);
               check("res_val", res_o, exp_res[nres]);
               if (z_yumi_o !== (N'(1) << slot)) hs_ok = 0;
            end else hs_ok = 0;
            nres++;
         end else if (z_yumi_o != '0) hs_ok = 0;
         if (done_o) begin
            done_seen = 1; done_cyc = c;
            break;
         end
      end
      check("done_seen", done_seen, 1);
      @(negedge clk);
      start_i = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0;
      #1;
      check("done_pulse", done_o, 0);
      check("busy_after", busy_o, 0);
      check("beats", kb, k);
      check("results", nres, (k > 0) ? N : 0);
      for (int i = 0; i < AH; i++) check("row_lane_count", lane_n[i], k);
      for (int j = 0; j < AW; j++) check("col_lane_count", col_n[j], k);
      check("lane_stream", stream_ok, 1);
      check("handshake", hs_ok, 1);
      if (rs_len > 0) check("row_stall_hold", rs_ok, 1);
      if (q_len > 0) check("res_stall_hold", q_ok && q_done && (snap_idx == 0), 1);
      if (chk_skew) check("skew_offset", first_v[1] - first_v[0], 1);
      if (k == 0) check("k0_done_cycle", done_cyc, 1);
   endtask

   task automatic load_vec(input int n);
      for (int i = 0; i < AH; i++)
         for (int kk = 0; kk < KMAX; kk++) amat[i][kk] = (kk < 4) ? 32'(vecs[n].a[i][kk]) : 32'd0;
      for (int kk = 0; kk < KMAX; kk++)
         for (int j = 0; j < AW; j++) bmat[kk][j] = (kk < 4) ? 32'(vecs[n].b[kk][j]) : 32'd0;
      for (int r = 0; r < N; r++) exp_res[r] = vecs[n].ex[r];
      load_job(int'(vecs[n].k));
   endtask

   task automatic apply_vec(input int n);
      load_vec(n);
      run_job(int'(vecs[n].k), int'(vecs[n].rs_at), int'(vecs[n].rs_len), int'(vecs[n].q_len), 1'b0, vecs[n].skew);
   endtask

   initial begin
      reset_i = 1'b1; start_i = 1'b0; k_i = '0; a_i = '0; b_i = '0;
      a_valid_i = 1'b0; b_valid_i = 1'b0; row_ready_i = '1; col_ready_i = '1;
      z_i = '0; z_valid_i = '1; res_ready_i = 1'b1;

      vecs[0] = '{k: 8'd2, a: mk_a(1, 2, 0, 3, 4, 0), b: mk_b(5, 6, 7, 8, 0, 0), rs_at: 8'd0, rs_len: 8'd0,
                  q_len: 8'd0, skew: 1'b1, ex: mk_e(19, 22, 43, 50)};
      vecs[1] = vecs[0]; vecs[1].rs_at = 8'd2; vecs[1].rs_len = 8'd3; vecs[1].skew = 1'b0;
      vecs[2] = vecs[0]; vecs[2].q_len = 8'd5;
      vecs[3] = '{k: 8'd1, a: mk_a(2, 0, 0, 3, 0, 0), b: mk_b(4, 5, 0, 0, 0, 0), rs_at: 8'd0, rs_len: 8'd0,
                  q_len: 8'd0, skew: 1'b1, ex: mk_e(8, 10, 12, 15)};
      vecs[4] = '{k: 8'd3, a: mk_a(1, 0, 2, 0, 1, 1), b: mk_b(1, 2, 3, 4, 5, 6), rs_at: 8'd0, rs_len: 8'd0,
                  q_len: 8'd0, skew: 1'b1, ex: mk_e(11, 14, 8, 10)};
      vecs[5] = '{k: 8'd0, a: '0, b: '0, rs_at: 8'd0, rs_len: 8'd0, q_len: 8'd0, skew: 1'b0, ex: '0};

      repeat (3) @(negedge clk);
      #1;
      check_quiet("reset");
      @(negedge clk);
      reset_i = 1'b0;

      for (int n = 0; n < NV; n++) apply_vec(n);

      // Reset after one accepted beat, then a fresh job.
      load_vec(0);
      @(negedge clk);
      start_i = 1'b1; k_i = KW'(2); a_valid_i = 1'b1; b_valid_i = 1'b1;
      a_i = {amat[1][0], amat[0][0]}; b_i = {bmat[0][1], bmat[0][0]};
      #1;
      @(negedge clk);
      start_i = 1'b0;
      #1;
      check("pre_reset_accept", a_ready_o, 1);
      @(negedge clk);
      a_i = {amat[1][1], amat[0][1]}; b_i = {bmat[1][1], bmat[1][0]};
      reset_i = 1'b1;
      #1;
      @(negedge clk);
      reset_i = 1'b0;
      #1;
      check_quiet("mid_reset");
      apply_vec(0);

      for (int t = 0; t < 20; t++) begin
         int k;
         k = $urandom_range(0, 6);
         for (int i = 0; i < AH; i++)
            for (int kk = 0; kk < KMAX; kk++) amat[i][kk] = $urandom;
         for (int kk = 0; kk < KMAX; kk++)
            for (int j = 0; j < AW; j++) bmat[kk][j] = $urandom;
         load_job(k);
         for (int r = 0; r < N; r++) exp_res[r] = z_i[((r / AW) + (r % AW) * AW)*WD +: WD];
         run_job(k, 0, 0, 0, 1'b1, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
